// File: rtl/ula_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
// Used by vram_arbiter, vram_arb_pick and vram_arbiter_if.
package ula_pkg;

  localparam int VRAM_AW = 13;
  localparam int VRAM_DW = 8;
  localparam int STAT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } vram_arb_state_t;

  typedef enum logic {
    OWN_VID,
    OWN_CPU
  } vram_owner_t;

  // WAIT-phase preload: ISSUE already covers one latency cycle.
  function automatic logic [1:0] lat_load(input int lat);
    return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Video, CPU and VRAM buses of the VRAM arbiter.
// slave = arbiter view, master = requesters/RAM view.
interface vram_arbiter_if;
  import ula_pkg::*;

  logic               vid_req;
  logic [VRAM_AW-1:0] vid_addr;
  logic               vid_ack;
  logic [VRAM_DW-1:0] vid_data;

  logic               cpu_req;
  logic               cpu_we;
  logic [VRAM_AW-1:0] cpu_addr;
  logic [VRAM_DW-1:0] cpu_din;
  logic               cpu_ack;
  logic [VRAM_DW-1:0] cpu_dout;
  logic               cpu_wait;

  logic [VRAM_AW-1:0] ram_addr;
  logic               ram_we;
  logic [VRAM_DW-1:0] ram_din;
  logic [VRAM_DW-1:0] ram_dout;

  modport slave (
    input  vid_req,
    input  vid_addr,
    output vid_ack,
    output vid_data,
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_din,
    output cpu_ack,
    output cpu_dout,
    output cpu_wait,
    output ram_addr,
    output ram_we,
    output ram_din,
    input  ram_dout
  );

  modport master (
    output vid_req,
    output vid_addr,
    input  vid_ack,
    input  vid_data,
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_din,
    input  cpu_ack,
    input  cpu_dout,
    input  cpu_wait,
    input  ram_addr,
    input  ram_we,
    input  ram_din,
    output ram_dout
  );

endinterface

// File: rtl/vram_arb_pick.sv
// Combinational winner selection between video and CPU.
// VID_PRIO=1: video wins ties; 0: alternate on ties.
module vram_arb_pick
  import ula_pkg::*;
#(
  parameter int VID_PRIO = 1
) (
  input  logic        vid_req,
  input  logic        cpu_req,
  input  vram_owner_t last_grant,
  output logic        grant_vid,
  output logic        grant_cpu
);

  logic vid_first;

  assign vid_first = (VID_PRIO != 0) ||
                     (last_grant == OWN_CPU);

  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    unique case (1'b1)
      (vid_req & cpu_req): begin
        grant_vid = vid_first;
        grant_cpu = ~vid_first;
      end
      (vid_req & ~cpu_req): begin
        grant_vid = 1'b1;
      end
      (~vid_req & cpu_req): begin
        grant_cpu = 1'b1;
      end
      default: begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch vs CPU access.
// Optional contention counter: define VRAM_ARB_STATS_EN.
module vram_arbiter
  import ula_pkg::*;
#(
  parameter int RAM_LAT  = 1,
  parameter int VID_PRIO = 1
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef VRAM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] cont_cycles,
`endif
  vram_arbiter_if.slave     bus
);

  vram_arb_state_t state;
  vram_arb_state_t state_nx;
  vram_owner_t     owner;
  vram_owner_t     last_grant;

  logic [1:0]         cnt;
  logic               wr;
  logic               vid_ack;
  logic               cpu_ack;
  logic [VRAM_DW-1:0] vid_data;
  logic [VRAM_DW-1:0] cpu_dout;
  logic [VRAM_AW-1:0] ram_addr;
  logic               ram_we;
  logic [VRAM_DW-1:0] ram_din;

  logic open;
  logic grant_vid;
  logic grant_cpu;
  logic grant;

  // The IDLE cycle carrying an ack never grants,
  // giving one access per RAM_LAT+3 cycles.
  assign open = ~(vid_ack | cpu_ack);

  vram_arb_pick #(
    .VID_PRIO (VID_PRIO)
  ) u_pick (
    .vid_req    (bus.vid_req & open),
    .cpu_req    (bus.cpu_req & open),
    .last_grant (last_grant),
    .grant_vid  (grant_vid),
    .grant_cpu  (grant_cpu)
  );

  assign grant = (state == IDLE) &
                 (grant_vid | grant_cpu);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = (RAM_LAT <= 1) ? ACK : WAIT;
      end
      WAIT: begin
        if (cnt <= 2'd1) begin
          state_nx = ACK;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner      <= OWN_VID;
      last_grant <= OWN_VID;
      cnt        <= '0;
      wr         <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_data   <= '0;
      cpu_dout   <= '0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_din    <= '0;
    end else begin
      ram_we  <= 1'b0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;

      if (grant) begin
        owner      <= grant_cpu ? OWN_CPU : OWN_VID;
        last_grant <= grant_cpu ? OWN_CPU : OWN_VID;
        ram_addr   <= grant_cpu ? bus.cpu_addr
                                : bus.vid_addr;
        ram_din    <= grant_cpu ? bus.cpu_din : ram_din;
        ram_we     <= grant_cpu & bus.cpu_we;
        wr         <= grant_cpu & bus.cpu_we;
      end

      if (state == ISSUE) begin
        cnt <= lat_load(RAM_LAT);
      end

      if (state == WAIT) begin
        cnt <= cnt - 2'd1;
      end

      if (state == ACK) begin
        if (owner == OWN_VID) begin
          vid_ack  <= 1'b1;
          vid_data <= bus.ram_dout;
        end else begin
          cpu_ack <= 1'b1;
          if (!wr) begin
            cpu_dout <= bus.ram_dout;
          end
        end
      end
    end
  end

  assign bus.vid_ack  = vid_ack;
  assign bus.vid_data = vid_data;
  assign bus.cpu_ack  = cpu_ack;
  assign bus.cpu_dout = cpu_dout;
  assign bus.cpu_wait = bus.cpu_req & ~cpu_ack;
  assign bus.ram_addr = ram_addr;
  assign bus.ram_we   = ram_we;
  assign bus.ram_din  = ram_din;

`ifdef VRAM_ARB_STATS_EN
  logic [STAT_W-1:0] cont_q;

  always_ff @(posedge CLK) begin
    if (RESET || stats_clr) begin
      cont_q <= '0;
    end else if (bus.cpu_wait && (cont_q != '1)) begin
      cont_q <= cont_q + 1'b1;
    end
  end

  assign cont_cycles = cont_q;
`endif

endmodule
